// File: rtl/int_to_ieee754_if.sv
// int_to_ieee754_if: valid/ready handshake bundle for the integer-to-float converter.
//   WIDTH      input integer width in bits
//   in_valid   source has in_data
//   in_ready   converter can accept a new integer
//   in_data    two's-complement signed integer
//   out_valid  out_data holds a finished result
//   out_ready  consumer takes out_data
//   out_data   IEEE 754 single-precision result
// modport slave is the converter's view; modport master is the source/consumer view.
interface int_to_ieee754_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/int_to_ieee754.sv
// int_to_ieee754: multi-cycle signed integer to IEEE 754 single converter,
// round-to-nearest-even, one conversion in flight.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    int_to_ieee754_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_data)
// Build option: INT_TO_IEEE754_FAST_NORM_EN selects single-cycle normalization
// (leading-zero count + barrel shift) instead of one shift per cycle. Results
// are identical; only latency differs.
module int_to_ieee754 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  int_to_ieee754_if.slave   bus
);

  localparam int unsigned PAD      = 32 - WIDTH;
  localparam int unsigned EXP_INIT = 127 + WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic [7:0]       exp;

  logic             accept;
  logic [WIDTH-1:0] in_mag;
  logic [30:0]      aligned;
  logic [22:0]      frac_raw;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [23:0]      frac_sum;

  assign accept = bus.in_valid && bus.in_ready;
  // Two's-complement negation; the most negative input maps to 2^(WIDTH-1), still representable unsigned.
  assign in_mag = bus.in_data[WIDTH-1] ? (WIDTH'(0) - bus.in_data) : bus.in_data;

`ifdef INT_TO_IEEE754_FAST_NORM_EN
  logic [5:0] lz;

  // Leading zeros of the magnitude; only consumed when the magnitude is nonzero.
  function automatic logic [5:0] lzc(input logic [WIDTH-1:0] v);
    logic [5:0] n;
    n = 6'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i]) n = 6'(int'(WIDTH) - 1 - i);
    end
    return n;
  endfunction

  assign lz = lzc(mag);
`endif

  // Fraction bits below the hidden one, left-aligned so bit 7 is guard and [6:0] is sticky.
  always_comb begin
    aligned  = 31'(mag[WIDTH-2:0]) << PAD;
    frac_raw = aligned[30:8];
    guard    = aligned[7];
    sticky   = |aligned[6:0];
    round_up = guard && (sticky || frac_raw[0]);
    frac_sum = {1'b0, frac_raw} + 24'(round_up);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = (in_mag == '0) ? DONE : NORM;
`ifdef INT_TO_IEEE754_FAST_NORM_EN
      NORM:  next_state = ROUND;
`else
      NORM:  if (mag[WIDTH-1]) next_state = ROUND;
`endif
      ROUND: next_state = DONE;
      DONE:  if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs; both are held low while reset is asserted.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    if (rst_n) begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
    end
  end

  // Datapath: capture, normalize, round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign         <= 1'b0;
      mag          <= '0;
      exp          <= '0;
      bus.out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign <= bus.in_data[WIDTH-1];
            mag  <= in_mag;
            exp  <= 8'(EXP_INIT);
            if (in_mag == '0) bus.out_data <= '0;
          end
        end
        NORM: begin
`ifdef INT_TO_IEEE754_FAST_NORM_EN
          mag <= mag << lz;
          exp <= exp - 8'(lz);
`else
          if (!mag[WIDTH-1]) begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
`endif
        end
        // A carry out of the fraction leaves frac_sum[22:0] zero and bumps the exponent.
        ROUND: bus.out_data <= {sign, exp + 8'(frac_sum[23]), frac_sum[22:0]};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_ieee754.sv
// tb_int_to_ieee754: bench for int_to_ieee754 at WIDTH=32 and WIDTH=8.
// Expected results come from an integer-arithmetic rounding model; a single
// compare process checks every presented result against the expected queue.
module tb_int_to_ieee754;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int_to_ieee754_if #(.WIDTH(32)) if32();
  int_to_ieee754_if #(.WIDTH(8))  if8();

  int_to_ieee754 #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  int_to_ieee754 #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp32_q[$];
  logic [31:0] exp8_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference conversion: locate the top set bit, then round the discarded bits to nearest-even.
  function automatic logic [31:0] model(input longint x);
    logic [63:0] m, q, rem, half;
    int p, e, sh;
    logic s;
    if (x == 0) return 32'h0;
    s = (x < 0);
    m = s ? 64'(-x) : 64'(x);
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e), q[22:0]};
  endfunction

  // Edges after the accepting edge until out_valid is seen high.
  function automatic int lat(input longint x, input int w);
    logic [63:0] m;
    int p;
    if (x == 0) return 0;
`ifdef INT_TO_IEEE754_FAST_NORM_EN
    return 2;
`else
    m = (x < 0) ? 64'(-x) : 64'(x);
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    return (w - 1 - p) + 2;
`endif
  endfunction

  function automatic bit rdy(input bit w8);
    return w8 ? if8.in_ready : if32.in_ready;
  endfunction

  function automatic bit ovld(input bit w8);
    return w8 ? if8.out_valid : if32.out_valid;
  endfunction

  task automatic set_in(input bit w8, input bit v, input logic [31:0] d);
    if (w8) begin
      if8.in_valid = v;
      if8.in_data  = d[7:0];
    end else begin
      if32.in_valid = v;
      if32.in_data  = d;
    end
  endtask

  task automatic set_ordy(input bit w8, input bit r);
    if (w8) if8.out_ready = r;
    else    if32.out_ready = r;
  endtask

  // Compare process: every cycle a result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if32.out_valid) begin
        checks++;
        if (exp32_q.size() == 0) begin
          failures++;
          $display("FAIL w32 unexpected out_valid: got out_data 0x%0h, required no result", if32.out_data);
        end else begin
          check("w32 out_data", if32.out_data, exp32_q[0]);
          check("w32 in_ready while busy", 32'(if32.in_ready), 32'd0);
          if (if32.out_ready) exp32_q.delete(0);
        end
      end
      if (if8.out_valid) begin
        checks++;
        if (exp8_q.size() == 0) begin
          failures++;
          $display("FAIL w8 unexpected out_valid: got out_data 0x%0h, required no result", if8.out_data);
        end else begin
          check("w8 out_data", if8.out_data, exp8_q[0]);
          check("w8 in_ready while busy", 32'(if8.in_ready), 32'd0);
          if (if8.out_ready) exp8_q.delete(0);
        end
      end
    end
  end

  // One full conversion: accept, measure latency, optional backpressure, handshake.
  task automatic convert(input bit w8, input logic [31:0] v, input int hold);
    longint x;
    int n;
    x = w8 ? longint'($signed(v[7:0])) : longint'($signed(v));
    n = 0;
    while (!rdy(w8) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready before accept", 32'(rdy(w8)), 32'd1);
    if (w8) exp8_q.push_back(model(x));
    else    exp32_q.push_back(model(x));
    set_in(w8, 1'b1, v);
    @(posedge clk); #1;
    set_in(w8, 1'b0, 32'h0);
    n = 0;
    while (!ovld(w8) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat(x, w8 ? 8 : 32)));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("out_valid held under backpressure", 32'(ovld(w8)), 32'd1);
    end
    set_ordy(w8, 1'b1);
    @(posedge clk); #1;
    set_ordy(w8, 1'b0);
    check("out_valid after handshake", 32'(ovld(w8)), 32'd0);
    check("in_ready after handshake", 32'(rdy(w8)), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0);
    set_in(1'b1, 1'b0, 32'h0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(if32.out_valid), 32'd0);
    check("reset out_data", if32.out_data, 32'h0);
    check("in_ready in reset", 32'(if32.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 32'(if32.in_ready), 32'd1);

    // Hand-computed values that pin the reference model.
    check("model 1",          model(64'sd1),           32'h3F800000);
    check("model -1",         model(-64'sd1),          32'hBF800000);
    check("model 0",          model(64'sd0),           32'h00000000);
    check("model -2^31",      model(-64'sd2147483648), 32'hCF000000);
    check("model 16777217",   model(64'sd16777217),    32'h4B800000);
    check("model 16777219",   model(64'sd16777219),    32'h4B800002);
    check("model 16777221",   model(64'sd16777221),    32'h4B800002);
    check("model 0x7FFFFFFF", model(64'sd2147483647),  32'h4F000000);
    check("model 100",        model(64'sd100),         32'h42C80000);
    check("model -3",         model(-64'sd3),          32'hC0400000);
    check("model -128",       model(-64'sd128),        32'hC3000000);
    check("model 127",        model(64'sd127),         32'h42FE0000);

    convert(1'b0, 32'h00000001, 0);
    convert(1'b0, 32'hFFFFFFFF, 0);
    convert(1'b0, 32'h00000000, 0);
    convert(1'b0, 32'h80000000, 0);
    convert(1'b0, 32'd16777217, 0);
    convert(1'b0, 32'd16777219, 0);
    convert(1'b0, 32'd16777221, 0);
    convert(1'b0, 32'h7FFFFFFF, 0);
    convert(1'b0, 32'd100, 5);

    // Abort a conversion of 5 while it is normalizing; its result must never appear.
    set_in(1'b0, 1'b1, 32'd5);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("in_ready during reset", 32'(if32.in_ready), 32'd0);
    check("out_valid during reset", 32'(if32.out_valid), 32'd0);
    @(posedge clk); #1;
    check("in_ready during reset held", 32'(if32.in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("in_ready after abort", 32'(if32.in_ready), 32'd1);
    convert(1'b0, 32'hFFFFFFFD, 0);

    convert(1'b1, 32'h00000080, 0);
    convert(1'b1, 32'h0000007F, 2);
    convert(1'b1, 32'h00000000, 0);
    convert(1'b1, 32'h00000001, 0);

    check("w32 expectations drained", 32'(exp32_q.size()), 32'd0);
    check("w8 expectations drained", 32'(exp8_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
